// File: rtl/cu_pkg.sv
// Shared definitions for the instruction-fetch control unit: FSM states,
// the NOP used as the reset instruction, and the default reset PC.
package cu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } cu_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] CU_RESET_PC = 32'h0000_0000;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/cu_if.sv
// Instruction-fetch front end: issues one memory read per fetch_start,
// holds the returned word for decode and advances or redirects the PC.
module cu_if
  import cu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = CU_RESET_PC,
  parameter int          FETCH_TIMEOUT = 15
) (
  input  logic        soc_clk,
  input  logic        IF_reset,
  input  logic        IF_stall,
  input  logic        fetch_start,
  input  logic [31:0] pc_increment,
  input  logic        pc_redirect,
  input  logic [31:0] redirect_target,
  input  logic        IDU_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] Cu_IR,
  output logic        Fetch_ready,
  output logic [31:0] PC,
  output logic        fetch_fault
);

  localparam logic [3:0] TMO = 4'(FETCH_TIMEOUT);

  cu_state_e   r_state;
  cu_state_e   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_fetch_ready;
  logic [3:0]  r_cnt;
  logic        r_captured;
  logic [3:0]  w_cnt_inc;

  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge soc_clk or posedge IF_reset) begin
    if (IF_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Redirect wins over everything; stall freezes the FSM otherwise.
  always_comb begin
    w_state_nxt = r_state;
    if (pc_redirect) begin
      w_state_nxt = S_IDLE;
    end else if (!IF_stall) begin
      case (r_state)
        S_IDLE:  if (fetch_start) w_state_nxt = word_aligned(r_pc) ? S_REQ : S_FAULT;
        S_REQ:   w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (imem_valid || r_captured) w_state_nxt = S_HOLD;
          else if (w_cnt_inc == TMO)    w_state_nxt = S_FAULT;
        end
        S_HOLD:  if (IDU_ready) w_state_nxt = S_IDLE;
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req    = (r_state == S_REQ) && !IF_stall && !pc_redirect;
    imem_addr   = (r_state == S_REQ) ? {r_pc[31:2], 2'b00} : 32'h0;
    fetch_fault = (r_state == S_FAULT);
  end

  // Memory cannot be stalled, so a word arriving during a stall is parked
  // in Cu_IR and handed to decode on the first unstalled cycle.
  always_ff @(posedge soc_clk or posedge IF_reset) begin
    if (IF_reset) begin
      r_pc          <= RESET_PC;
      r_ir          <= NOP_INSTR;
      r_fetch_ready <= 1'b0;
      r_cnt         <= 4'd0;
      r_captured    <= 1'b0;
    end else if (pc_redirect) begin
      r_pc          <= redirect_target;
      r_fetch_ready <= 1'b0;
      r_captured    <= 1'b0;
    end else if (IF_stall) begin
      if (r_state == S_WAIT && imem_valid && !r_captured) begin
        r_ir       <= imem_rdata;
        r_captured <= 1'b1;
      end
    end else begin
      case (r_state)
        S_REQ: r_cnt <= 4'd0;
        S_WAIT: begin
          if (r_captured) begin
            r_fetch_ready <= 1'b1;
            r_captured    <= 1'b0;
          end else if (imem_valid) begin
            r_ir          <= imem_rdata;
            r_fetch_ready <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_HOLD: begin
          if (IDU_ready) begin
            r_fetch_ready <= 1'b0;
            r_pc          <= r_pc + pc_increment;
          end
        end
        default: ;
      endcase
    end
  end

  assign PC          = r_pc;
  assign Cu_IR       = r_ir;
  assign Fetch_ready = r_fetch_ready;

endmodule

// File: tb/tb_cu_if.sv
// Directed bench for cu_if: fetch, wrap, timeout, redirect, stall and
// misalignment scenarios with hand-computed expectations.
module tb_cu_if;

  logic        soc_clk = 1'b0;
  logic        IF_reset;
  logic        IF_stall;
  logic        fetch_start;
  logic [31:0] pc_increment;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        IDU_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] Cu_IR;
  logic        Fetch_ready;
  logic [31:0] PC;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  cu_if dut (
    .soc_clk(soc_clk), .IF_reset(IF_reset), .IF_stall(IF_stall),
    .fetch_start(fetch_start), .pc_increment(pc_increment),
    .pc_redirect(pc_redirect), .redirect_target(redirect_target),
    .IDU_ready(IDU_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .Cu_IR(Cu_IR),
    .Fetch_ready(Fetch_ready), .PC(PC), .fetch_fault(fetch_fault)
  );

  always #5 soc_clk = ~soc_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    pc_redirect = 1'b1; redirect_target = tgt;
    tick();
    pc_redirect = 1'b0;
  endtask

  // Drives a fetch from IDLE through to HOLD with a one-cycle wait.
  task automatic fetch_word(input logic [31:0] word);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    imem_valid = 1'b1; imem_rdata = word;
    tick();
    imem_valid = 1'b0;
  endtask

  initial begin
    IF_reset = 1'b1; IF_stall = 1'b0; fetch_start = 1'b0; pc_increment = 32'h0;
    pc_redirect = 1'b0; redirect_target = 32'h0; IDU_ready = 1'b0;
    imem_rdata = 32'h0; imem_valid = 1'b0;
    #1;
    check("rst_pc", PC, 32'h0);
    check("rst_ir", Cu_IR, 32'h0000_0013);
    check("rst_fr", {31'b0, Fetch_ready}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);
    tick(); tick();
    IF_reset = 1'b0;
    tick();

    // Basic fetch, data arriving on the second wait cycle.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    #1;
    check("req_strobe", {31'b0, imem_req}, 32'h1);
    check("req_addr", imem_addr, 32'h0);
    tick();
    check("req_one_cycle", {31'b0, imem_req}, 32'h0);
    tick();
    check("wait_fr_low", {31'b0, Fetch_ready}, 32'h0);
    imem_valid = 1'b1; imem_rdata = 32'h00A0_0093;
    tick();
    imem_valid = 1'b0;
    check("basic_ir", Cu_IR, 32'h00A0_0093);
    check("basic_fr", {31'b0, Fetch_ready}, 32'h1);
    tick();
    check("hold_fr", {31'b0, Fetch_ready}, 32'h1);
    IDU_ready = 1'b1; pc_increment = 32'd4;
    tick();
    IDU_ready = 1'b0;
    check("accept_pc", PC, 32'h4);
    check("accept_fr", {31'b0, Fetch_ready}, 32'h0);

    // PC wraps modulo 2^32.
    redirect(32'hFFFF_FFFC);
    check("redir_pc", PC, 32'hFFFF_FFFC);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_valid = 1'b0;
    IDU_ready = 1'b1; pc_increment = 32'd4;
    tick();
    IDU_ready = 1'b0;
    check("wrap_pc", PC, 32'h0);

    // Stall in HOLD with IDU_ready high freezes everything.
    fetch_word(32'hABCD_0001);
    IF_stall = 1'b1; IDU_ready = 1'b1; pc_increment = 32'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", PC, 32'h0);
      check("stall_ir", Cu_IR, 32'hABCD_0001);
      check("stall_fr", {31'b0, Fetch_ready}, 32'h1);
    end
    IF_stall = 1'b0;
    tick();
    IDU_ready = 1'b0;
    check("unstall_pc", PC, 32'h8);
    check("unstall_fr", {31'b0, Fetch_ready}, 32'h0);

    // Redirect during WAIT, stale data afterwards is dropped.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    redirect(32'h40);
    check("redir_wait_pc", PC, 32'h40);
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_valid = 1'b0;
    check("stale_ir", Cu_IR, 32'hABCD_0001);
    check("stale_fr", {31'b0, Fetch_ready}, 32'h0);

    // Timeout after 15 empty WAIT cycles.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("tmo_not_yet", {31'b0, fetch_fault}, 32'h0);
    tick();
    check("tmo_fault", {31'b0, fetch_fault}, 32'h1);
    check("tmo_req", {31'b0, imem_req}, 32'h0);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("fault_sticky", {31'b0, fetch_fault}, 32'h1);
    redirect(32'h100);
    check("fault_clear", {31'b0, fetch_fault}, 32'h0);
    check("fault_pc", PC, 32'h100);

    // Asynchronous reset mid-WAIT abandons the fetch.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    #2 IF_reset = 1'b1;
    #1;
    check("async_pc", PC, 32'h0);
    check("async_ir", Cu_IR, 32'h0000_0013);
    tick();
    IF_reset = 1'b0;
    imem_valid = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_valid = 1'b0;
    check("post_rst_ir", Cu_IR, 32'h0000_0013);
    check("post_rst_fr", {31'b0, Fetch_ready}, 32'h0);

    // Data during a stall in WAIT is captured, readiness deferred.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    IF_stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h0000_0055;
    tick();
    imem_valid = 1'b0;
    check("scap_fr_low", {31'b0, Fetch_ready}, 32'h0);
    tick();
    check("scap_fr_held", {31'b0, Fetch_ready}, 32'h0);
    IF_stall = 1'b0;
    tick();
    check("scap_fr", {31'b0, Fetch_ready}, 32'h1);
    check("scap_ir", Cu_IR, 32'h0000_0055);

    // Redirect outranks IDU_ready in HOLD.
    IDU_ready = 1'b1; pc_increment = 32'd4;
    redirect(32'h200);
    IDU_ready = 1'b0;
    check("prio_pc", PC, 32'h200);
    check("prio_fr", {31'b0, Fetch_ready}, 32'h0);

    // Misaligned PC faults without a memory request.
    redirect(32'h102);
    fetch_start = 1'b1;
    #1;
    check("mis_req_idle", {31'b0, imem_req}, 32'h0);
    tick();
    fetch_start = 1'b0;
    check("mis_fault", {31'b0, fetch_fault}, 32'h1);
    check("mis_req", {31'b0, imem_req}, 32'h0);
    tick();
    check("mis_req_later", {31'b0, imem_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_if.md
CU_IF -- requirements
Module: cu_if

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, default 15, max cycles in WAIT without imem_valid (range 1-15).
REQ-003 soc_clk  in  1  single clock; all state updates on posedge.
REQ-004 IF_reset  in  1  reset, asynchronous, active-high.
REQ-005 IF_stall  in  1  freeze all fetch state while high.
REQ-006 fetch_start  in  1  one-cycle request from CU to fetch the instruction at PC.
REQ-007 pc_increment  in  32  PC advance from decode, applied on consumer accept.
REQ-008 pc_redirect  in  1  branch/jump redirect strobe.
REQ-009 redirect_target  in  32  new PC, valid with pc_redirect.
REQ-010 IDU_ready  in  1  decode has accepted Cu_IR.
REQ-011 imem_req  out  1  memory read strobe, one cycle per request.
REQ-012 imem_addr  out  32  word-aligned fetch address.
REQ-013 imem_rdata  in  32  instruction word returned by memory.
REQ-014 imem_valid  in  1  imem_rdata valid this cycle.
REQ-015 Cu_IR  out  32  registered fetched instruction to decode.
REQ-016 Fetch_ready  out  1  registered; high while Cu_IR holds an unconsumed instruction.
REQ-017 PC  out  32  address of the instruction in flight or next to fetch.
REQ-018 fetch_fault  out  1  sticky fault flag (misaligned PC or timeout).

Function
REQ-019 FSM states IDLE, REQ, WAIT, HOLD, FAULT; one transition max per cycle.
REQ-020 IDLE: fetch_start & !IF_stall -> REQ if PC[1:0]==0, else -> FAULT.
REQ-021 REQ: imem_req=1, imem_addr=PC for exactly one cycle; timeout counter cleared; -> WAIT.
REQ-022 WAIT: imem_valid -> Cu_IR<=imem_rdata, Fetch_ready<=1, -> HOLD; else counter+1; counter reaching FETCH_TIMEOUT -> FAULT.
REQ-023 HOLD: Fetch_ready and Cu_IR held stable until IDU_ready; on IDU_ready, Fetch_ready<=0, PC<=PC+pc_increment (mod 2^32, wraps), -> IDLE.
REQ-024 Fetch_ready rises exactly one cycle after the accepted imem_valid edge; never glitches (decode samples its posedge).
REQ-025 pc_redirect (any state): PC<=redirect_target, Fetch_ready<=0, fetch_fault<=0, -> IDLE; outranks IDU_ready, imem_valid, fetch_start and IF_stall in the same cycle.
REQ-026 imem_valid outside WAIT is ignored (drops stale data after redirect).
REQ-027 IF_stall (no redirect): state, PC, Cu_IR, counter and Fetch_ready frozen; imem_req forced 0; IDU_ready ignored.
REQ-028 imem_valid during IF_stall in WAIT is captured (memory is not stallable); transition to HOLD deferred to first unstalled cycle.
REQ-029 FAULT: fetch_fault=1, imem_req=0, Fetch_ready=0; exit only via pc_redirect or IF_reset.
REQ-030 fetch_start outside IDLE is ignored.

Reset
REQ-031 IF_reset high: state IDLE, PC=RESET_PC, Cu_IR=32'h0000_0013 (NOP), Fetch_ready=0, imem_req=0, imem_addr=0, fetch_fault=0, counter=0, immediately (asynchronous).
REQ-032 Reset asserted mid-WAIT or mid-HOLD abandons the fetch; a later imem_valid is ignored per REQ-026.

Structure
REQ-033 Shared package cu_pkg holds the FSM state enum, NOP_INSTR constant, and default RESET_PC.
REQ-034 Flat module; no sub-module (timeout counter inline, 4 bits).

Verification
REQ-035 Reset, fetch_start, imem_valid with 32'h00A00093 after 2 cycles -> imem_addr=0, Cu_IR=32'h00A00093, Fetch_ready=1; IDU_ready with pc_increment=4 -> PC=4.
REQ-036 PC=32'hFFFF_FFFC, pc_increment=4, accept -> PC=32'h0000_0000.
REQ-037 No imem_valid for 15 cycles in WAIT -> fetch_fault=1; pc_redirect to 32'h100 -> fault clears, PC=32'h100, IDLE.
REQ-038 Redirect to 32'h40 during WAIT, stale imem_valid next cycle -> Cu_IR unchanged, Fetch_ready=0.
REQ-039 IF_stall high 3 cycles in HOLD with IDU_ready high -> PC, Cu_IR, Fetch_ready unchanged until stall drops.
REQ-040 Redirect to 32'h102 then fetch_start -> FAULT, imem_req never asserted.
